// File: rtl/touch_event_encoder_pkg.sv
// Shared widths, event type and helpers for the touch event encoder.
// The hold field of touch_event_t exists only when TOUCH_HOLD_TIMER_EN is defined.
package touch_pkg;

   localparam int NUM_KEYS  = 12;
   localparam int KEY_IDX_W = 4;
   localparam int HOLD_W    = 16;
   localparam int DEB_W     = 4;

   typedef struct packed {
      logic [KEY_IDX_W-1:0] key;
      logic                 press;
`ifdef TOUCH_HOLD_TIMER_EN
      logic [HOLD_W-1:0]    hold;
`endif
   } touch_event_t;

   // Priority pick used by the scanner: lowest electrode index wins.
   function automatic logic [KEY_IDX_W-1:0] lowest_set_index(input logic [NUM_KEYS-1:0] bits);
      logic [KEY_IDX_W-1:0] idx;
      idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (bits[i]) begin
            idx = KEY_IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/touch_event_encoder_if.sv
// Event stream bundle from the touch encoder to voice allocation.
// The encoder drives through the master modport and the consumer uses the slave modport.
interface touch_event_encoder_if;
   import touch_pkg::*;

   logic                 event_valid_out;
   logic                 event_ready_in;
   logic [KEY_IDX_W-1:0] event_key_out;
   logic                 event_press_out;
   logic [HOLD_W-1:0]    event_hold_out;

   modport master (
      output event_valid_out,
      output event_key_out,
      output event_press_out,
      output event_hold_out,
      input  event_ready_in
   );

   modport slave (
      input  event_valid_out,
      input  event_key_out,
      input  event_press_out,
      input  event_hold_out,
      output event_ready_in
   );

endinterface

// File: rtl/touch_event_encoder_fifo.sv
// Show-ahead event FIFO for the touch encoder; DEPTH must be a power of two (>= 2).
// Head data reads as zero while empty so the event outputs stay quiet after reset.
module touch_event_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_pop;
   logic             do_push;

   // Extra pointer bit separates full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/touch_event_encoder.sv
// Debounces the 12-electrode touch bitmap at a fixed tick rate and queues press/release events.
// Defining TOUCH_HOLD_TIMER_EN adds per-key hold timers reported on release events.
module touch_event_encoder
   import touch_pkg::*;
#(
   parameter int SAMPLE_PERIOD  = 100_000,
   parameter int DEBOUNCE_COUNT = 4,
   parameter int FIFO_DEPTH     = 16
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [NUM_KEYS-1:0]   touch_status_in,
   input  logic                  touch_valid_in,
   touch_event_encoder_if.master event_bus,
   output logic [NUM_KEYS-1:0]   key_state_out,
   output logic                  overflow_out
);

   localparam int                TICK_W     = $clog2(SAMPLE_PERIOD);
   localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SAMPLE_PERIOD - 1);
   localparam logic [DEB_W-1:0]  DEB_TARGET = DEB_W'(DEBOUNCE_COUNT);
   localparam int                EVENT_W    = $bits(touch_event_t);

   logic [TICK_W-1:0]    tick_cnt;
   logic                 sample;
   logic [NUM_KEYS-1:0]  key_state;
   logic [NUM_KEYS-1:0]  key_state_next;
   logic [NUM_KEYS-1:0]  flip;
   logic [DEB_W-1:0]     deb_cnt  [NUM_KEYS];
   logic [DEB_W-1:0]     deb_next [NUM_KEYS];
   logic [NUM_KEYS-1:0]  pending;
   logic [NUM_KEYS-1:0]  pending_press;
   logic [NUM_KEYS-1:0]  scan_clear;
   logic [KEY_IDX_W-1:0] scan_idx;
   touch_event_t         push_event;
   touch_event_t         head_event;
   logic [EVENT_W-1:0]   head_data;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_push;
   logic                 fifo_pop;

   assign sample        = (tick_cnt == TICK_LAST) && touch_valid_in;
   assign key_state_out = key_state;

   // A key flips only after DEBOUNCE_COUNT consecutive sampled disagreements.
   always_comb begin
      key_state_next = key_state;
      flip           = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         deb_next[i] = deb_cnt[i];
         if (sample) begin
            if (touch_status_in[i] == key_state[i]) begin
               deb_next[i] = '0;
            end else if (deb_cnt[i] + DEB_W'(1) == DEB_TARGET) begin
               deb_next[i]       = '0;
               key_state_next[i] = ~key_state[i];
               flip[i]           = 1'b1;
            end else begin
               deb_next[i] = deb_cnt[i] + DEB_W'(1);
            end
         end
      end
   end

`ifdef TOUCH_HOLD_TIMER_EN
   logic [HOLD_W-1:0] hold_cnt     [NUM_KEYS];
   logic [HOLD_W-1:0] hold_inc     [NUM_KEYS];
   logic [HOLD_W-1:0] pending_hold [NUM_KEYS];

   always_comb begin
      for (int i = 0; i < NUM_KEYS; i++) begin
         hold_inc[i] = (&hold_cnt[i]) ? hold_cnt[i] : hold_cnt[i] + HOLD_W'(1);
      end
   end

   // The release tick itself counts toward the hold, so the event takes the incremented value.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            hold_cnt[i]     <= '0;
            pending_hold[i] <= '0;
         end
      end else if (sample) begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (flip[i] && key_state_next[i]) begin
               hold_cnt[i] <= '0;
            end else if (key_state[i]) begin
               hold_cnt[i] <= hold_inc[i];
            end
            if (flip[i]) begin
               pending_hold[i] <= key_state_next[i] ? '0 : hold_inc[i];
            end
         end
      end
   end
`endif

   // Scanner: one pending key per cycle, lowest index first; it never waits on the FIFO.
   always_comb begin
      scan_idx   = lowest_set_index(pending);
      scan_clear = '0;
      if (|pending) begin
         scan_clear[scan_idx] = 1'b1;
      end
      push_event       = '0;
      push_event.key   = scan_idx;
      push_event.press = pending_press[scan_idx];
`ifdef TOUCH_HOLD_TIMER_EN
      push_event.hold  = pending_hold[scan_idx];
`endif
   end

   assign fifo_push = |pending;
   assign fifo_pop  = ~fifo_empty & event_bus.event_ready_in;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         tick_cnt      <= '0;
         key_state     <= '0;
         pending       <= '0;
         pending_press <= '0;
         overflow_out  <= 1'b0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         tick_cnt      <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
         key_state     <= key_state_next;
         pending       <= (pending & ~scan_clear) | flip;
         pending_press <= (pending_press & ~flip) | (flip & key_state_next);
         for (int i = 0; i < NUM_KEYS; i++) begin
            deb_cnt[i] <= deb_next[i];
         end
         if (fifo_push && fifo_full && !fifo_pop) begin
            overflow_out <= 1'b1;
         end
      end
   end

   touch_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVENT_W)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .push_data (push_event),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head_event                = touch_event_t'(head_data);
   assign event_bus.event_valid_out = ~fifo_empty;
   assign event_bus.event_key_out   = head_event.key;
   assign event_bus.event_press_out = head_event.press;
`ifdef TOUCH_HOLD_TIMER_EN
   assign event_bus.event_hold_out  = head_event.hold;
`else
   assign event_bus.event_hold_out  = '0;
`endif

endmodule
